imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Boot-time writer for the core's instruction memory.
- Receives a byte stream carrying a length header, payload words and an optional checksum.
- Assembles big-endian 32-bit instruction words and writes them to the instruction RAM write port at consecutive byte addresses (step 4), matching the core's PC stepping.
- Holds the processor in reset until a load completes successfully.

Parameters:
- BASE_ADDR, 32'd0: byte address of the first written word; the core's PC reset value.
- MAX_WORDS, 1024: largest accepted word count; a header above this is an error.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle pulse; begins a load when in IDLE, DONE or ERR.
- byte_valid  input  1  byte_data is valid this cycle.
- byte_data  input  8  stream byte.
- byte_ready  output  1  loader accepts a byte this cycle.
- imem_we  output  1  instruction RAM write strobe, one cycle per word.
- imem_addr  output  32  byte address of the word being written.
- imem_wdata  output  32  instruction word.
- cpu_rst  output  1  reset to the processor core; high unless a load has completed OK.
- busy  output  1  a load is in progress.
- done  output  1  last load succeeded; sticky until the next start or rst.
- err  output  1  last load failed; sticky until the next start or rst.

Behaviour:
- Reset (sync, active-high):
  - state=IDLE.
  - Outputs: imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, cpu_rst=1, busy=0, done=0, err=0, byte_ready=0.
  - Word count, byte index and checksum accumulator all cleared.
  - rst mid-load aborts immediately, with the same values. Partially written RAM contents are left as they are.
- States: IDLE, LEN_HI, LEN_LO, DATA, CSUM, DONE, ERR.
- Byte acceptance: a byte is accepted on a cycle where byte_valid && byte_ready.
- byte_ready is combinational: high in LEN_HI, LEN_LO, DATA and CSUM; low elsewhere. Bytes presented in other states are dropped.
- start in IDLE, DONE or ERR:
  - goes to LEN_HI next cycle;
  - sets busy=1, done=0, err=0, cpu_rst=1;
  - sets imem_addr=BASE_ADDR, clears checksum and byte index.
- start while busy is ignored.
- LEN_HI: accepted byte becomes count[15:8]; go to LEN_LO.
- LEN_LO: accepted byte becomes count[7:0]. Then, if count==0 or count>MAX_WORDS, go to ERR; otherwise go to DATA.
- DATA:
  - Bytes shift into the word register MSB first; byte 0 goes to [31:24].
  - A 2-bit byte index counts 0..3 and wraps.
  - Every payload byte is XORed into the 8-bit checksum accumulator.
  - On acceptance of byte 3:
    - next cycle imem_we=1 for exactly one cycle, with imem_wdata equal to the assembled word and imem_addr equal to the current address;
    - the cycle after the strobe, imem_addr advances by 4 (32-bit wrap, no saturation);
    - words_left decrements.
  - The write latency from the 4th byte to the strobe is exactly 1 cycle.
  - Back-to-back bytes sustain one word per 4 cycles, with no stall.
  - When the last word is accepted, go to CSUM.
- CSUM: if the accepted byte equals the accumulator, go to DONE; otherwise go to ERR.
- DONE: busy=0, done=1; cpu_rst deasserts on the same cycle state becomes DONE.
- ERR: busy=0, err=1, cpu_rst stays 1.
- The last word's imem_we may coincide with the CSUM state. The core stays in reset during that write because cpu_rst stays high until DONE.
- Simultaneous start and byte_valid in IDLE: start wins and the byte is dropped (byte_ready=0 in IDLE).
- start in DONE re-asserts cpu_rst the next cycle, allowing a reload.

Optional Feature:
- Macro LOADER_CHECKSUM_EN.
- Defined: the CSUM state and checksum byte are present, as above.
- Undefined:
  - no CSUM state and no accumulator logic;
  - DATA goes directly to DONE on acceptance of the last word's 4th byte;
  - done rises one cycle after that, coinciding with the final imem_we;
  - err arises only from a bad length.

Test Plan:
- Basic load (CHECKSUM_EN defined), no gaps:
  - Stimulus: rst, start, then bytes 00 02 | 20 01 00 05 | 08 00 00 03 | csum.
  - csum = XOR of the 8 payload bytes = 0x2F.
  - Expect 2 imem_we pulses: addr 0x0 data 0x20010005, addr 0x4 data 0x08000003.
  - Then done=1, cpu_rst=0, err=0.
- Bad checksum: same stream with csum 0x00 -> both words are written, then err=1, done=0, cpu_rst=1.
- Bad length:
  - header 00 00 -> ERR right after LEN_LO, no imem_we.
  - header 04 01 with MAX_WORDS=1024 -> ERR.
- Gapped stream: byte_valid toggled randomly, with invalid bytes 0xFF in between -> identical writes to the basic load; each imem_we comes exactly 1 cycle after the 4th accepted byte.
- Reset mid-load: rst asserted after 6 payload bytes -> next cycle IDLE with all reset values. A following start plus the full basic stream gives the basic-load results at addr 0x0.
- Reload and ignore: start asserted while busy has no effect. A second start after DONE re-asserts cpu_rst next cycle and restarts at BASE_ADDR.

Source files
------------

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot loader writing a byte stream into instruction RAM and holding the core in reset
// Optional checksum trailer byte enabled by defining LOADER_CHECKSUM_EN.
module imem_loader #(
   parameter logic [31:0] BASE_ADDR = 32'd0,
   parameter int          MAX_WORDS = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   output logic        byte_ready,
   output logic        imem_we,
   output logic [31:0] imem_addr,
   output logic [31:0] imem_wdata,
   output logic        cpu_rst,
   output logic        busy,
   output logic        done,
   output logic        err
);

   typedef enum logic [2:0] {
      IDLE, LEN_HI, LEN_LO, DATA,
`ifdef LOADER_CHECKSUM_EN
      CSUM,
`endif
      DONE, ERR
   } state_t;

   localparam logic [16:0] MAX_LEN = 17'(MAX_WORDS);

   state_t      state, state_next;
   logic [15:0] words_left;
   logic [1:0]  byte_idx;
   logic [23:0] word;
   logic        accept;
   logic        can_start;
   logic [15:0] len_full;
   logic        len_bad;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]  csum;
`endif

   assign accept    = byte_valid && byte_ready;
   assign can_start = (state == IDLE) || (state == DONE) || (state == ERR);
   assign len_full  = {words_left[15:8], byte_data};
   assign len_bad   = (len_full == 16'd0) || ({1'b0, len_full} > MAX_LEN);

   assign done    = (state == DONE);
   assign err     = (state == ERR);
   assign cpu_rst = (state != DONE);
   assign busy    = byte_ready;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      byte_ready = 1'b0;
      case (state)
         IDLE, DONE, ERR: begin
            if (start) state_next = LEN_HI;
         end
         LEN_HI: begin
            byte_ready = 1'b1;
            if (byte_valid) state_next = LEN_LO;
         end
         LEN_LO: begin
            byte_ready = 1'b1;
            if (byte_valid) state_next = len_bad ? ERR : DATA;
         end
         DATA: begin
            byte_ready = 1'b1;
            if (byte_valid && (byte_idx == 2'd3) && (words_left == 16'd1)) begin
`ifdef LOADER_CHECKSUM_EN
               state_next = CSUM;
`else
               state_next = DONE;
`endif
            end
         end
`ifdef LOADER_CHECKSUM_EN
         CSUM: begin
            byte_ready = 1'b1;
            if (byte_valid) state_next = (byte_data == csum) ? DONE : ERR;
         end
`endif
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         imem_we    <= 1'b0;
         imem_addr  <= BASE_ADDR;
         imem_wdata <= 32'd0;
         words_left <= 16'd0;
         byte_idx   <= 2'd0;
         word       <= 24'd0;
`ifdef LOADER_CHECKSUM_EN
         csum       <= 8'd0;
`endif
      end else begin
         imem_we <= 1'b0;
         // address steps the cycle after each strobe so the strobe sees the current word's address
         if (imem_we) imem_addr <= imem_addr + 32'd4;
         case (state)
            LEN_HI: if (accept) words_left[15:8] <= byte_data;
            LEN_LO: if (accept) words_left[7:0]  <= byte_data;
            DATA: begin
               if (accept) begin
                  word     <= {word[15:0], byte_data};
                  byte_idx <= byte_idx + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                  csum     <= csum ^ byte_data;
`endif
                  if (byte_idx == 2'd3) begin
                     imem_we    <= 1'b1;
                     imem_wdata <= {word, byte_data};
                     words_left <= words_left - 16'd1;
                  end
               end
            end
            default: ;
         endcase
         if (start && can_start) begin
            imem_addr  <= BASE_ADDR;
            byte_idx   <= 2'd0;
            words_left <= 16'd0;
`ifdef LOADER_CHECKSUM_EN
            csum       <= 8'd0;
`endif
         end
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - randomized self-checking bench for imem_loader against a word-list model
// Honours LOADER_CHECKSUM_EN to decide whether a checksum trailer byte is sent.
module tb_imem_loader;

   localparam logic [31:0] BASE = 32'd0;
   localparam int          MAXW = 1024;
`ifdef LOADER_CHECKSUM_EN
   localparam bit CS = 1'b1;
`else
   localparam bit CS = 1'b0;
`endif

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      int          cyc;
   } wr_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        byte_valid = 1'b0;
   logic [7:0]  byte_data = 8'hFF;
   logic        byte_ready, imem_we, cpu_rst, busy, done, err;
   logic [31:0] imem_addr, imem_wdata;

   int          cyc = 0;
   int          total = 0;
   int          bad = 0;
   wr_t         cap[$];
   wr_t         expq[$];
   logic [31:0] pay[$];

   imem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
      .clk(clk), .rst(rst), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
      .byte_ready(byte_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .cpu_rst(cpu_rst), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (imem_we === 1'b1) cap.push_back('{addr: imem_addr, data: imem_wdata, cyc: cyc});
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset();
      chk("rst_we", imem_we, 0);
      chk("rst_addr", imem_addr, BASE);
      chk("rst_wdata", imem_wdata, 0);
      chk("rst_cpu_rst", cpu_rst, 1);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_ready", byte_ready, 0);
   endtask

   // a byte presented alongside start must be dropped
   task automatic do_start();
      start = 1'b1; byte_valid = 1'b1; byte_data = 8'h12;
      @(posedge clk); #1;
      start = 1'b0; byte_valid = 1'b0; byte_data = 8'hFF;
      @(negedge clk);
      chk("start_busy", busy, 1);
      chk("start_ready", byte_ready, 1);
      chk("start_cpu_rst", cpu_rst, 1);
      chk("start_done", done, 0);
      chk("start_err", err, 0);
      chk("start_addr", imem_addr, BASE);
      @(posedge clk); #1;
   endtask

   task automatic send(input logic [7:0] b, input bit gapped, output int pc);
      int gap;
      gap = gapped ? int'($urandom_range(0, 3)) : 0;
      repeat (gap) begin
         byte_valid = 1'b0; byte_data = 8'hFF;
         @(posedge clk); #1;
      end
      byte_valid = 1'b1; byte_data = b; pc = cyc;
      @(negedge clk);
      chk("ready", byte_ready, 1);
      @(posedge clk); #1;
      byte_valid = 1'b0; byte_data = 8'hFF;
   endtask

   task automatic run_load(input logic [15:0] hdr, input bit gapped, input bit bad_cs, input bit poke);
      int pc;
      logic [7:0] cs, b;
      bit ok;
      cap.delete(); expq.delete(); cs = 8'h00;
      do_start();
      send(hdr[15:8], gapped, pc);
      send(hdr[7:0], gapped, pc);
      if (hdr == 16'd0 || int'(hdr) > MAXW) begin
         @(negedge clk);
         chk("len_err", err, 1);
         chk("len_done", done, 0);
         chk("len_cpu_rst", cpu_rst, 1);
         chk("len_busy", busy, 0);
         repeat (3) @(posedge clk);
         #1;
         chk("len_nwrites", 32'(cap.size()), 0);
         return;
      end
      for (int i = 0; i < int'(hdr); i++) begin
         for (int j = 0; j < 4; j++) begin
            b = pay[i][31 - 8*j -: 8];
            cs ^= b;
            send(b, gapped, pc);
            if (j == 3) expq.push_back('{addr: BASE + 32'(4*i), data: pay[i], cyc: pc + 1});
            if (poke && i == 0 && j == 1) begin
               start = 1'b1;
               @(posedge clk); #1;
               start = 1'b0;
            end
         end
      end
      ok = 1'b1;
      if (CS) begin
         send(bad_cs ? ~cs : cs, gapped, pc);
         ok = !bad_cs;
      end
      @(negedge clk);
      chk("end_done", done, ok);
      chk("end_err", err, !ok);
      chk("end_cpu_rst", cpu_rst, !ok);
      chk("end_busy", busy, 0);
      repeat (3) @(posedge clk);
      #1;
      chk("end_addr", imem_addr, BASE + 32'(4*int'(hdr)));
      chk("nwrites", 32'(cap.size()), 32'(expq.size()));
      for (int k = 0; k < expq.size() && k < cap.size(); k++) begin
         chk("wr_addr", cap[k].addr, expq[k].addr);
         chk("wr_data", cap[k].data, expq[k].data);
         chk("wr_cycle", 32'(cap[k].cyc), 32'(expq[k].cyc));
      end
   endtask

   task automatic basic_pay();
      pay.delete();
      pay.push_back(32'h20010005);
      pay.push_back(32'h08000003);
   endtask

   initial begin
      int pc, n;
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      chk_reset();
      @(posedge clk); #1;
      rst = 1'b0;

      basic_pay();
      run_load(16'd2, 1'b0, 1'b0, 1'b0);
      run_load(16'd2, 1'b0, 1'b1, 1'b0);
      run_load(16'h0000, 1'b0, 1'b0, 1'b0);
      run_load(16'h0401, 1'b0, 1'b0, 1'b0);
      run_load(16'd2, 1'b1, 1'b0, 1'b0);

      // reset after six payload bytes, then a clean reload from BASE
      do_start();
      send(8'h00, 1'b0, pc);
      send(8'h02, 1'b0, pc);
      for (int j = 0; j < 6; j++) send(j < 4 ? pay[0][31 - 8*j -: 8] : pay[1][31 - 8*(j-4) -: 8], 1'b0, pc);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk_reset();
      @(posedge clk); #1;
      run_load(16'd2, 1'b0, 1'b0, 1'b0);
      run_load(16'd2, 1'b1, 1'b0, 1'b1);

      for (int t = 0; t < 8; t++) begin
         n = int'($urandom_range(1, 8));
         pay.delete();
         for (int i = 0; i < n; i++) pay.push_back($urandom);
         run_load(16'(n), bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
      end

      pay.delete();
      for (int i = 0; i < MAXW; i++) pay.push_back($urandom);
      run_load(16'(MAXW), 1'b0, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
